sdram_demo_nios2_cpu_debug_mem_arbiter: RTL and testbench
=========================================================

SDRAM_DEMO_NIOS2_CPU_DEBUG_MEM_ARBITER -- requirements
Module: sdram_demo_nios2_cpu_debug_mem_arbiter

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset, named as listed below.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 jdo  in  38  JTAG debug data, sysclk domain.
REQ-005 take_action_ocimem_a  in  1  one-cycle strobe: load the JTAG address from jdo[33:26].
REQ-006 take_action_ocimem_b  in  1  one-cycle strobe: JTAG write of jdo[34:3].
REQ-007 take_no_action_ocimem_a  in  1  one-cycle strobe: JTAG read.
REQ-008 av_address  in  8; av_read  in  1; av_write  in  1; av_writedata  in  32; av_byteenable  in  4  CPU debug-slave request.
REQ-009 av_readdata  out  32; av_waitrequest  out  1  CPU debug-slave response.
REQ-010 ram_addr  out  8; ram_wdata  out  32; ram_byteen  out  4; ram_we  out  1; ram_re  out  1; ram_rdata  in  32  single-port OCI RAM with 1-cycle read latency.
REQ-011 MonDReg  out  32  last JTAG read result.
REQ-012 monitor_ready  out  1  MonDReg holds the result of the latest JTAG read.
REQ-013 jtag_busy  out  1  a JTAG operation is pending or in progress.
REQ-014 jtag_overrun  out  1  sticky flag: a JTAG strobe was dropped.

Function
REQ-015 FSM states: IDLE, AV_WR, AV_RD, AV_RD_DONE, JT_WR, JT_RD, JT_RD_DONE. Every non-IDLE state lasts exactly one cycle. AV_WR, AV_RD_DONE, JT_WR and JT_RD_DONE return to IDLE. AV_RD goes to AV_RD_DONE. JT_RD goes to JT_RD_DONE.
REQ-016 JTAG pending register (one entry: op, addr, data):
- captured on take_action_ocimem_b or take_no_action_ocimem_a when jtag_busy=0;
- a strobe arriving while jtag_busy=1 is dropped and sets jtag_overrun.
REQ-017 take_action_ocimem_a:
- loads the JTAG address register from jdo[33:26] in the same cycle, with no RAM access;
- clears jtag_overrun;
- does not change the address already captured in a pending operation.
REQ-018 After each JTAG write or read is captured, the JTAG address register increments by 1; 255 wraps to 0.
REQ-019 Arbitration, evaluated only in IDLE. Candidates: Avalon request (av_read|av_write) and JTAG pending.
- Only one candidate present: grant it.
- Both present: grant the requester not granted last (last_grant flag).
- After reset, the first contested grant goes to JTAG.
REQ-020 If av_read and av_write are both high, treat the request as a write.
REQ-021 Avalon address, data and byteenable are sampled on the IDLE cycle that grants the request.
REQ-022 av_waitrequest:
- = (av_read|av_write) in every cycle except the completion cycle;
- low for exactly one cycle on completion: AV_WR for a write, AV_RD_DONE for a read.
REQ-023 Avalon write timing: request granted in IDLE cycle N; in N+1, ram_we=1 with the sampled address, data and byteenable, and av_waitrequest=0.
REQ-024 Avalon read timing: ram_re=1 in N+1; ram_rdata is captured at the end of N+2; in N+3 (AV_RD_DONE), av_readdata holds that value and av_waitrequest=0.
- Correction to REQ-015 for reads: AV_RD spans N+1 and N+2, so an Avalon read occupies three cycles after the grant.
- The same applies to JT_RD.
REQ-025 JTAG write: JT_WR asserts ram_we with ram_byteen=4'hF.
REQ-026 JTAG read: JT_RD asserts ram_re. In JT_RD_DONE, MonDReg is loaded from the captured data and monitor_ready goes to 1.
REQ-027 monitor_ready clears in the cycle after a JTAG read is captured.
REQ-028 ram_we and ram_re are never high together, and each is high only in its own state.
REQ-029 jtag_busy = pending valid OR state in {JT_WR, JT_RD, JT_RD_DONE}. It falls in the cycle after the JT_WR or JT_RD_DONE state.
REQ-030 An Avalon request that drops before completion (a protocol violation) still finishes its RAM access. No response is required for it.

Reset
REQ-031 When reset asserts, asynchronously:
- state=IDLE;
- pending entry cleared;
- ram_we=0, ram_re=0;
- av_waitrequest follows REQ-022 from IDLE;
- MonDReg=0, monitor_ready=0, jtag_busy=0, jtag_overrun=0;
- JTAG address=0, last_grant=Avalon;
- av_readdata=0.
REQ-032 Reset mid-operation aborts the access with no further RAM strobes. The first grant after release follows REQ-019.

Verification
REQ-033 Avalon write to addr 0x12, data 0xDEADBEEF, byteenable 0x3 -> ram_we for 1 cycle at 0x12 with 0xDEADBEEF/0x3; av_waitrequest low in that same cycle.
REQ-034 Avalon read of addr 0x12 with ram_rdata=0xCAFEF00D -> av_readdata=0xCAFEF00D and av_waitrequest low exactly 3 cycles after the grant.
REQ-035 JTAG sequence: address load 0xFF; write 0x11111111; read with ram_rdata=0x5A5A5A5A ->
- write goes to 0xFF; read goes to 0x00 (wrap);
- MonDReg=0x5A5A5A5A; monitor_ready 0 -> 1.
REQ-036 Avalon read held continuously while JTAG issues two reads -> grants after reset: JTAG, Avalon, JTAG; no starvation.
REQ-037 Second JTAG strobe while jtag_busy=1 -> no extra RAM access and jtag_overrun=1; next take_action_ocimem_a clears it.
REQ-038 Reset asserted during JT_RD -> ram_re drops immediately; after release MonDReg=0 and jtag_busy=0.

Source files
------------

// File: rtl/sdram_demo_nios2_cpu_debug_mem_arbiter.sv
// Arbitrates the single-port OCI debug RAM between the CPU debug slave (Avalon)
// and JTAG monitor accesses, with one-entry JTAG buffering and fair arbitration.
module sdram_demo_nios2_cpu_debug_mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  input  logic [7:0]  av_address,
  input  logic        av_read,
  input  logic        av_write,
  input  logic [31:0] av_writedata,
  input  logic [3:0]  av_byteenable,
  output logic [31:0] av_readdata,
  output logic        av_waitrequest,
  output logic [7:0]  ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_byteen,
  output logic        ram_we,
  output logic        ram_re,
  input  logic [31:0] ram_rdata,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        jtag_busy,
  output logic        jtag_overrun
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] AV_WR      = 3'd1;
  localparam logic [2:0] AV_RD      = 3'd2;
  localparam logic [2:0] AV_RD_DONE = 3'd3;
  localparam logic [2:0] JT_WR      = 3'd4;
  localparam logic [2:0] JT_RD      = 3'd5;
  localparam logic [2:0] JT_RD_DONE = 3'd6;

  logic [2:0]  state;
  logic        rd_phase;
  logic        last_grant_jtag;
  logic        pend_valid;
  logic        pend_wr;
  logic [7:0]  pend_addr;
  logic [31:0] pend_data;
  logic [7:0]  jtag_addr;
  logic        av_req;
  logic        jt_strobe;
  logic        jt_capture;
  logic        jt_drop;
  logic        grant_jt;
  logic        grant_av;
  logic        unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  always_comb begin
    jtag_busy      = pend_valid | (state == JT_WR) | (state == JT_RD) | (state == JT_RD_DONE);
    av_req         = av_read | av_write;
    jt_strobe      = take_action_ocimem_b | take_no_action_ocimem_a;
    jt_capture     = jt_strobe & ~jtag_busy;
    jt_drop        = jt_strobe & jtag_busy;
    grant_jt       = (state == IDLE) & pend_valid & (~av_req | ~last_grant_jtag);
    grant_av       = (state == IDLE) & av_req & ~grant_jt;
    av_waitrequest = av_req & ~((state == AV_WR) | (state == AV_RD_DONE));
    ram_we         = (state == AV_WR) | (state == JT_WR);
    // Reads span two cycles; the strobe is issued only in the first so each read is one access.
    ram_re         = ((state == AV_RD) | (state == JT_RD)) & ~rd_phase;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rd_phase        <= 1'b0;
      last_grant_jtag <= 1'b0;
      ram_addr        <= '0;
      ram_wdata       <= '0;
      ram_byteen      <= '0;
      av_readdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          rd_phase <= 1'b0;
          if (grant_jt) begin
            state           <= pend_wr ? JT_WR : JT_RD;
            ram_addr        <= pend_addr;
            ram_wdata       <= pend_data;
            ram_byteen      <= '1;
            last_grant_jtag <= 1'b1;
          end else if (grant_av) begin
            state           <= av_write ? AV_WR : AV_RD;
            ram_addr        <= av_address;
            ram_wdata       <= av_writedata;
            ram_byteen      <= av_byteenable;
            last_grant_jtag <= 1'b0;
          end
        end
        AV_RD, JT_RD: begin
          rd_phase <= ~rd_phase;
          if (rd_phase) begin
            state <= (state == AV_RD) ? AV_RD_DONE : JT_RD_DONE;
            if (state == AV_RD)
              av_readdata <= ram_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid    <= 1'b0;
      pend_wr       <= 1'b0;
      pend_addr     <= '0;
      pend_data     <= '0;
      jtag_addr     <= '0;
      jtag_overrun  <= 1'b0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
    end else begin
      if (grant_jt)
        pend_valid <= 1'b0;
      // A simultaneous write and read strobe is taken as the write.
      if (jt_capture) begin
        pend_valid <= 1'b1;
        pend_wr    <= take_action_ocimem_b;
        pend_addr  <= jtag_addr;
        pend_data  <= jdo[34:3];
        if (!take_action_ocimem_b)
          monitor_ready <= 1'b0;
      end
      if (take_action_ocimem_a)
        jtag_addr <= jdo[33:26];
      else if (jt_capture)
        jtag_addr <= jtag_addr + 8'd1;
      if (jt_drop)
        jtag_overrun <= 1'b1;
      else if (take_action_ocimem_a)
        jtag_overrun <= 1'b0;
      if ((state == JT_RD) && rd_phase) begin
        MonDReg       <= ram_rdata;
        monitor_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_demo_nios2_cpu_debug_mem_arbiter.sv
// Self-checking bench: Avalon vector table, JTAG sequences, and a RAM-access scoreboard.
module tb_sdram_demo_nios2_cpu_debug_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [7:0]  av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byteen;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        jtag_busy;
  logic        jtag_overrun;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ram_op_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int unsigned lat;
  } av_vec_t;

  ram_op_t     exp_q[$];
  ram_op_t     mon_e;
  av_vec_t     vecs[6];
  int unsigned checks;
  int unsigned errors;
  logic [31:0] rdata_drv;

  sdram_demo_nios2_cpu_debug_mem_arbiter dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_byteenable           (av_byteenable),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_byteen              (ram_byteen),
    .ram_we                  (ram_we),
    .ram_re                  (ram_re),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .jtag_busy               (jtag_busy),
    .jtag_overrun            (jtag_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with one-cycle read latency; garbage outside the valid data cycle.
  always @(posedge clk)
    ram_rdata <= ram_re ? rdata_drv : 32'hBAD0BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_op(input logic we, input logic [7:0] addr, input logic [31:0] data,
                         input logic [3:0] be);
    ram_op_t o;
    o.we = we; o.addr = addr; o.data = data; o.be = be;
    exp_q.push_back(o);
  endtask

  always @(negedge clk) begin
    if (ram_we || ram_re) begin
      chk("ram_we_re_exclusive", {31'd0, ram_we & ram_re}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ram_op actual we=%0b re=%0b addr=%h expected none",
                 ram_we, ram_re, ram_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ram_op_is_write", {31'd0, ram_we}, {31'd0, mon_e.we});
        chk("ram_addr", {24'd0, ram_addr}, {24'd0, mon_e.addr});
        if (mon_e.we) begin
          chk("ram_wdata", ram_wdata, mon_e.data);
          chk("ram_byteen", {28'd0, ram_byteen}, {28'd0, mon_e.be});
        end
      end
    end
  end

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // kind 0: address load, 1: write, 2: read. Called and returns at posedge+1.
  task automatic jt_strobe(input int kind, input logic [31:0] val);
    jdo = '0;
    case (kind)
      0: begin jdo[33:26] = val[7:0]; take_action_ocimem_a = 1'b1; end
      1: begin jdo[34:3] = val; take_action_ocimem_b = 1'b1; end
      default: take_no_action_ocimem_a = 1'b1;
    endcase
    to_drive();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (!jtag_busy) break;
    end
    chk(name, {31'd0, n < 30}, 32'd1);
    to_drive();
  endtask

  task automatic av_xact(input av_vec_t v);
    int unsigned lat;
    push_op(v.wr, v.addr, v.wdata, v.be);
    rdata_drv     = v.rdata;
    av_read       = v.rd;
    av_write      = v.wr;
    av_address    = v.addr;
    av_writedata  = v.wdata;
    av_byteenable = v.be;
    @(negedge clk);
    chk("av_wait_in_grant", {31'd0, av_waitrequest}, 32'd1);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!av_waitrequest) begin
        lat = k;
        break;
      end
    end
    chk("av_latency", lat, v.lat);
    if (v.rd && !v.wr)
      chk("av_readdata", av_readdata, v.rdata);
    to_drive();
    av_read  = 1'b0;
    av_write = 1'b0;
    to_drive();
  endtask

  initial begin
    int n;
    int unsigned acnt;
    vecs[0] = '{1'b0, 1'b1, 8'h12, 32'hDEADBEEF, 4'h3, 32'h0, 1};
    vecs[1] = '{1'b1, 1'b0, 8'h12, 32'h0, 4'hF, 32'hCAFEF00D, 3};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 32'h00000001, 4'hF, 32'h0, 1};
    vecs[3] = '{1'b1, 1'b0, 8'hFF, 32'h0, 4'hF, 32'h80000001, 3};
    vecs[4] = '{1'b1, 1'b1, 8'h7E, 32'h12345678, 4'hC, 32'h0, 1};
    vecs[5] = '{1'b1, 1'b0, 8'h7E, 32'h0, 4'hF, 32'hFFFFFFFF, 3};

    checks = 0; errors = 0;
    reset = 1'b1; jdo = '0; rdata_drv = '0;
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0; av_byteenable = '0;

    @(negedge clk);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_re", {31'd0, ram_re}, 32'd0);
    chk("rst_mondreg", MonDReg, 32'd0);
    chk("rst_monitor_ready", {31'd0, monitor_ready}, 32'd0);
    chk("rst_jtag_busy", {31'd0, jtag_busy}, 32'd0);
    chk("rst_jtag_overrun", {31'd0, jtag_overrun}, 32'd0);
    chk("rst_av_readdata", av_readdata, 32'd0);
    chk("rst_waitreq_idle", {31'd0, av_waitrequest}, 32'd0);
    av_read = 1'b1;
    #1 chk("rst_waitreq_req", {31'd0, av_waitrequest}, 32'd1);
    av_read = 1'b0;
    to_drive();
    reset = 1'b0;
    to_drive();

    for (int i = 0; i < 6; i++) av_xact(vecs[i]);

    // JTAG: load 0xFF, write, read wraps to 0x00, second read shows ready clearing.
    jt_strobe(0, 32'hFF);
    push_op(1'b1, 8'hFF, 32'h11111111, 4'hF);
    jt_strobe(1, 32'h11111111);
    @(negedge clk);
    chk("jt_busy_set", {31'd0, jtag_busy}, 32'd1);
    wait_idle("jt_wr_done");
    rdata_drv = 32'h5A5A5A5A;
    push_op(1'b0, 8'h00, 32'h0, 4'hF);
    jt_strobe(2, 32'h0);
    wait_idle("jt_rd_done");
    @(negedge clk);
    chk("jt_mondreg", MonDReg, 32'h5A5A5A5A);
    chk("jt_monitor_ready", {31'd0, monitor_ready}, 32'd1);
    to_drive();
    rdata_drv = 32'h0F0F0F0F;
    push_op(1'b0, 8'h01, 32'h0, 4'hF);
    jt_strobe(2, 32'h0);
    @(negedge clk);
    chk("jt_ready_cleared", {31'd0, monitor_ready}, 32'd0);
    wait_idle("jt_rd2_done");
    @(negedge clk);
    chk("jt_mondreg2", MonDReg, 32'h0F0F0F0F);
    chk("jt_monitor_ready2", {31'd0, monitor_ready}, 32'd1);
    to_drive();

    // Overrun: strobe while busy is dropped and does not advance the address.
    jt_strobe(0, 32'h40);
    rdata_drv = 32'h24682468;
    push_op(1'b0, 8'h40, 32'h0, 4'hF);
    jt_strobe(2, 32'h0);
    jt_strobe(1, 32'hEEEEEEEE);
    @(negedge clk);
    chk("ovr_set", {31'd0, jtag_overrun}, 32'd1);
    wait_idle("ovr_rd_done");
    @(negedge clk);
    chk("ovr_mondreg", MonDReg, 32'h24682468);
    to_drive();
    push_op(1'b1, 8'h41, 32'h33333333, 4'hF);
    jt_strobe(1, 32'h33333333);
    wait_idle("ovr_wr_done");
    @(negedge clk);
    chk("ovr_sticky", {31'd0, jtag_overrun}, 32'd1);
    to_drive();
    jt_strobe(0, 32'h20);
    @(negedge clk);
    chk("ovr_cleared", {31'd0, jtag_overrun}, 32'd0);
    to_drive();

    // Address load while an op is pending leaves the pending address alone.
    push_op(1'b0, 8'h20, 32'h0, 4'hF);
    jt_strobe(2, 32'h0);
    jt_strobe(0, 32'h30);
    wait_idle("pend_rd_done");
    push_op(1'b1, 8'h30, 32'h44444444, 4'hF);
    jt_strobe(1, 32'h44444444);
    wait_idle("pend_wr_done");

    // Fairness after reset: JTAG, Avalon, JTAG, Avalon with Avalon read held.
    reset = 1'b1;
    to_drive();
    to_drive();
    reset = 1'b0;
    rdata_drv = 32'h13572468;
    push_op(1'b0, 8'h00, 32'h0, 4'hF);
    push_op(1'b0, 8'h55, 32'h0, 4'hF);
    push_op(1'b0, 8'h01, 32'h0, 4'hF);
    push_op(1'b0, 8'h55, 32'h0, 4'hF);
    jt_strobe(2, 32'h0);
    av_read = 1'b1;
    av_address = 8'h55;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (monitor_ready) break;
    end
    chk("fair_j1_done", {31'd0, n < 20}, 32'd1);
    to_drive();
    jt_strobe(2, 32'h0);
    acnt = 0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!av_waitrequest) acnt++;
      if (acnt == 2) break;
    end
    chk("fair_av_completions", acnt, 32'd2);
    chk("fair_av_readdata", av_readdata, 32'h13572468);
    to_drive();
    av_read = 1'b0;
    @(negedge clk);
    chk("fair_mondreg", MonDReg, 32'h13572468);
    chk("fair_sb_drained", exp_q.size(), 32'd0);
    to_drive();

    // Reset during JT_RD aborts the read.
    push_op(1'b0, 8'h02, 32'h0, 4'hF);
    jt_strobe(2, 32'h0);
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ram_re) break;
    end
    chk("abort_reached_rd", {31'd0, n < 10}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort_ram_re", {31'd0, ram_re}, 32'd0);
    chk("abort_busy", {31'd0, jtag_busy}, 32'd0);
    chk("abort_mondreg", MonDReg, 32'd0);
    chk("abort_av_readdata", av_readdata, 32'd0);
    to_drive();
    to_drive();
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_abort_busy", {31'd0, jtag_busy}, 32'd0);
    chk("post_abort_mondreg", MonDReg, 32'd0);
    to_drive();

    // First contested grant after release goes to JTAG again.
    push_op(1'b0, 8'h00, 32'h0, 4'hF);
    push_op(1'b0, 8'h66, 32'h0, 4'hF);
    jt_strobe(2, 32'h0);
    av_read = 1'b1;
    av_address = 8'h66;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!av_waitrequest) break;
    end
    chk("post_rst_av_done", {31'd0, n < 20}, 32'd1);
    to_drive();
    av_read = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
